hazard_stall_scheduler: RTL

- Central stall/flush sequencer for the 5-stage pipeline; sits beside the ID stage.
- Combines three stall causes into one set of per-stage enable, flush and bubble controls:
  - load-use data hazards,
  - branch-operand hazards (branch resolved in ID),
  - multi-cycle data-memory waits.
- A small FSM carries multi-cycle sequences such as the second bubble for load→branch.
- Also keeps a sticky memory-timeout flag and a stall-cycle performance counter.

---
 rtl/hazard_stall_scheduler.sv | 64 ++++++
 1 files changed

// File: rtl/hazard_stall_scheduler.sv
// hazard_stall_scheduler: merges load-use, branch-operand and data-memory-wait stalls into per-stage pipeline controls
module hazard_stall_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_rd,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       state_o,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {RUN = 2'd0, BR_LOAD2 = 2'd1} state_t;
    state_t state, state_n;
    logic [WW-1:0] wait_cnt;
    logic hz, memwait, stall;
    assign hz = (ex_rd != 5'd0) & ((ex_rd == id_rs1 & id_use_rs1) | (ex_rd == id_rs2 & id_use_rs2));
    assign memwait = mem_req & ~dmem_ready;
    assign stall = ~rst_i & ~memwait & ((state != RUN) | (hz & (ex_memread | (id_is_branch & ex_regwrite))));
    assign pipe_freeze = ~rst_i & memwait;
    assign pc_write = ~rst_i & ~memwait & ~stall;
    assign ifid_write = pc_write;
    assign idex_bubble = rst_i | stall;
    assign ifid_flush = rst_i | (pc_write & id_is_branch & branch_taken);
    assign state_o = state;
    always_comb begin
        state_n = state;
        if (rst_i)
            state_n = RUN;
        else if (!memwait)
            state_n = (state == RUN && ex_memread && hz && id_is_branch) ? BR_LOAD2 : RUN;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= pipe_freeze ? ((wait_cnt == WW'(TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1) : '0;
            if (pipe_freeze && wait_cnt == WW'(TIMEOUT - 1))
                mem_timeout <= 1'b1;
            if (!pc_write && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule
